ads1292_packetizer: RTL
=======================

Name: ads1292_packetizer

Overview:
- Downstream stage of the ADS1292 filter chain.
- Accepts 24-bit filtered samples through the filter's VALID/ACK handshake and buffers them in a small FIFO.
- Frames each sample into a 7-byte packet (2 header bytes, sequence, 3 data bytes, checksum).
- Streams packets byte-by-byte to the UART transmitter over a valid/ready byte interface.

Parameters:
- FIFO_DEPTH, 4, sample buffer depth in entries; power of two, minimum 2.
- HEADER0, 8'hAA, first packet byte.
- HEADER1, 8'h55, second packet byte.

Ports:
- i_CLK  input  1  clock; all logic on rising edge.
- i_RST  input  1  synchronous active-high reset.
- i_FILTERED_DATA  input  24  filtered sample, two's complement.
- i_FILTERED_DATA_VALID  input  1  upstream holds high until it sees ACK.
- o_FILTERED_DATA_ACK  output  1  one-cycle pulse when a sample is captured.
- o_TX_DATA  output  8  current packet byte.
- o_TX_VALID  output  1  o_TX_DATA valid.
- i_TX_READY  input  1  transmitter accepts the byte on an edge where VALID&&READY.
- o_FIFO_LEVEL  output  $clog2(FIFO_DEPTH)+1  number of samples buffered, excluding the packet in flight.

Behaviour:
- Reset (i_RST high at an edge):
  - ACK=0, TX_VALID=0, TX_DATA=0, FIFO_LEVEL=0.
  - Sequence counter=0, state=ST_IDLE, FIFO pointers=0.
  - Applies mid-packet: the partial packet is abandoned and buffered samples are discarded.
- Capture rule:
  - On an edge where VALID=1, ACK=0 and level<FIFO_DEPTH: write the sample, level+1, ACK<=1.
  - ACK is forced to 0 on the following edge.
  - No capture while ACK=1; this guarantees one capture per upstream transaction, since upstream drops VALID the edge after seeing VALID&&ACK.
- Full:
  - level==FIFO_DEPTH means no capture and ACK stays 0, so upstream stalls.
  - Full is evaluated from the registered level; a same-edge pop does not free space for a same-edge push.
- Simultaneous push and pop on one edge: both happen and level is unchanged.
- Pointers: read/write pointers wrap modulo FIFO_DEPTH.
- FSM, 2 states:
  - ST_IDLE:
    - TX_VALID=0.
    - If level>0: pop the head into the sample register, compute CHK = SEQ ^ D[23:16] ^ D[15:8] ^ D[7:0].
    - Byte index<=0, TX_DATA<=HEADER0, TX_VALID<=1, go to ST_SEND.
  - ST_SEND:
    - TX_DATA/TX_VALID are held stable while READY=0.
    - On VALID&&READY with index<6: index+1, TX_DATA<=next byte.
    - On VALID&&READY with index==6: TX_VALID<=0, SEQ<=SEQ+1 (8-bit, 255 wraps to 0), go to ST_IDLE.
- Byte order: HEADER0, HEADER1, SEQ, D[23:16], D[15:8], D[7:0], CHK.
- Latency:
  - Sample captured at edge t0 (ACK high in cycle t0..t0+1).
  - Pop at edge t0+1 if idle; TX_VALID high with HEADER0 from t0+1.
  - Back-to-back packets have one idle cycle between the last byte handshake and the next HEADER0.
- Outputs are all registered; there is no combinational path from i_TX_READY or i_FILTERED_DATA_VALID to any output.

Test Plan:
- Reset, then one sample 24'h123456 with READY=1 → ACK pulses exactly one cycle; TX bytes AA 55 00 12 34 56 70 on 7 consecutive cycles; FIFO_LEVEL returns to 0.
- Second sample 24'hABCDEF after first packet → AA 55 01 AB CD EF 88; SEQ increments.
- READY held low, six samples offered with upstream-style handshake:
  - Samples 1–5 are ACKed: 1 in flight, 4 buffered, FIFO_LEVEL=4.
  - Sample 6 VALID is held with ACK=0.
  - Release READY → after packet 1's seventh byte and the IDLE pop, sample 6 is ACKed.
  - All 6 packets emerge in order, SEQ 0..5.
- READY toggled randomly (stall mid-packet at index 3) → TX_DATA/TX_VALID stable while stalled; byte stream identical to the READY=1 case.
- 257 samples streamed → SEQ goes 254, 255, 0; checksum is correct across the wrap.
- i_RST asserted while sending byte index 4 with 2 samples buffered → next cycle TX_VALID=0, FIFO_LEVEL=0, ACK=0; next sample produces a packet with SEQ=00 starting at HEADER0.

Source files
------------

// File: rtl/ads1292_packetizer.sv
// ADS1292 packetizer: buffers 24-bit filtered samples in a small FIFO and frames
// each one as AA 55 SEQ D2 D1 D0 CHK on a valid/ready byte stream toward the UART.
module ads1292_packetizer #(
   parameter int         FIFO_DEPTH = 4,
   parameter logic [7:0] HEADER0    = 8'hAA,
   parameter logic [7:0] HEADER1    = 8'h55
) (
   input  logic                         i_CLK,
   input  logic                         i_RST,
   input  logic [23:0]                  i_FILTERED_DATA,
   input  logic                         i_FILTERED_DATA_VALID,
   output logic                         o_FILTERED_DATA_ACK,
   output logic [7:0]                   o_TX_DATA,
   output logic                         o_TX_VALID,
   input  logic                         i_TX_READY,
   output logic [$clog2(FIFO_DEPTH):0]  o_FIFO_LEVEL
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [2:0] LAST_IDX = 3'd6;

   typedef enum logic {ST_IDLE, ST_SEND} state_t;

   state_t             r_state,    w_state_nxt;
   logic [2:0]         r_idx,      w_idx_nxt;
   logic [7:0]         r_seq,      w_seq_nxt;
   logic [23:0]        r_sample,   w_sample_nxt;
   logic [7:0]         r_chk,      w_chk_nxt;
   logic [7:0]         r_tx_data,  w_tx_data_nxt;
   logic               r_tx_valid, w_tx_valid_nxt;
   logic               r_ack;
   logic [LVL_W-1:0]   r_level,    w_level_nxt;
   logic [PTR_W-1:0]   r_wr_ptr,   r_rd_ptr;
   logic [23:0]        r_mem [FIFO_DEPTH];

   logic               w_push;
   logic               w_pop;
   logic [23:0]        w_head;

   // Full is judged on the registered level only, so a same-edge pop never frees a slot.
   assign w_push = i_FILTERED_DATA_VALID && !r_ack && (r_level < LVL_W'(FIFO_DEPTH));
   assign w_pop  = (r_state == ST_IDLE) && (r_level != '0);
   assign w_head = r_mem[r_rd_ptr];

   function automatic logic [7:0] byte_sel(input logic [2:0]  idx,
                                           input logic [7:0]  seq,
                                           input logic [23:0] d,
                                           input logic [7:0]  chk);
      case (idx)
         3'd0:    byte_sel = HEADER0;
         3'd1:    byte_sel = HEADER1;
         3'd2:    byte_sel = seq;
         3'd3:    byte_sel = d[23:16];
         3'd4:    byte_sel = d[15:8];
         3'd5:    byte_sel = d[7:0];
         3'd6:    byte_sel = chk;
         default: byte_sel = 8'h00;
      endcase
   endfunction

   always_comb begin
      // NOTE: every next-value gets its hold default first so no path leaves it unassigned (no latches).
      w_state_nxt    = r_state;
      w_idx_nxt      = r_idx;
      w_seq_nxt      = r_seq;
      w_sample_nxt   = r_sample;
      w_chk_nxt      = r_chk;
      w_tx_data_nxt  = r_tx_data;
      w_tx_valid_nxt = r_tx_valid;

      case (r_state)
         ST_IDLE: begin
            w_tx_valid_nxt = 1'b0;
            if (w_pop) begin
               w_sample_nxt   = w_head;
               w_chk_nxt      = r_seq ^ w_head[23:16] ^ w_head[15:8] ^ w_head[7:0];
               w_idx_nxt      = 3'd0;
               w_tx_data_nxt  = HEADER0;
               w_tx_valid_nxt = 1'b1;
               w_state_nxt    = ST_SEND;
            end
         end
         ST_SEND: begin
            if (r_tx_valid && i_TX_READY) begin
               if (r_idx == LAST_IDX) begin
                  w_tx_valid_nxt = 1'b0;
                  w_seq_nxt      = r_seq + 8'd1;
                  w_state_nxt    = ST_IDLE;
               end else begin
                  w_idx_nxt     = r_idx + 3'd1;
                  w_tx_data_nxt = byte_sel(r_idx + 3'd1, r_seq, r_sample, r_chk);
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase

      case ({w_push, w_pop})
         2'b10:   w_level_nxt = r_level + LVL_W'(1);
         2'b01:   w_level_nxt = r_level - LVL_W'(1);
         default: w_level_nxt = r_level;
      endcase
   end

   always_ff @(posedge i_CLK) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (i_RST) begin
         r_state    <= ST_IDLE;
         r_idx      <= 3'd0;
         r_seq      <= 8'd0;
         r_sample   <= 24'd0;
         r_chk      <= 8'd0;
         r_tx_data  <= 8'd0;
         r_tx_valid <= 1'b0;
         r_ack      <= 1'b0;
         r_level    <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_idx      <= w_idx_nxt;
         r_seq      <= w_seq_nxt;
         r_sample   <= w_sample_nxt;
         r_chk      <= w_chk_nxt;
         r_tx_data  <= w_tx_data_nxt;
         r_tx_valid <= w_tx_valid_nxt;
         r_ack      <= w_push;
         r_level    <= w_level_nxt;
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
   end

   // NOTE: the sample storage is not reset; the level and pointers alone decide what is valid.
   always_ff @(posedge i_CLK) begin
      if (!i_RST && w_push) r_mem[r_wr_ptr] <= i_FILTERED_DATA;
   end

   assign o_FILTERED_DATA_ACK = r_ack;
   assign o_TX_DATA           = r_tx_data;
   assign o_TX_VALID          = r_tx_valid;
   assign o_FIFO_LEVEL        = r_level;

endmodule
